// File: rtl/game_ctrl.sv
// Game sequencer for the stacking game: runs the IDLE/COUNTDOWN/PLAY/PAUSED/OVER flow
// and drives the datapath run enable, new-game clear, speed level and high score.
module game_ctrl #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int LEVEL_STEP    = 10,
  parameter int MAX_LEVEL     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       end_game,
  input  logic [6:0] score,
  output logic       run,
  output logic       clear,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [2:0] level,
  output logic [6:0] high_score
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic [2:0]    level_reg, level_next;
  logic [7:0]    thr_reg, thr_next;
  logic [6:0]    hs_reg, hs_next;
  logic          run_reg, run_next;
  logic          clear_reg, clear_next;
  logic          over_first_reg, over_first_next;
  logic          start_q, pause_q;
  logic          s_rise, p_rise, step, legal;

  assign s_rise = start & ~start_q;
  assign p_rise = pause & ~pause_q;
  assign legal  = (state_reg <= ST_OVER);
  assign step   = ({1'b0, score} >= thr_reg) && (level_reg < 3'(MAX_LEVEL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      presc_reg      <= '0;
      cnt_reg        <= '0;
      level_reg      <= '0;
      thr_reg        <= 8'(LEVEL_STEP);
      hs_reg         <= '0;
      run_reg        <= 1'b0;
      clear_reg      <= 1'b0;
      over_first_reg <= 1'b0;
      start_q        <= 1'b0;
      pause_q        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= presc_next;
      cnt_reg        <= cnt_next;
      level_reg      <= level_next;
      thr_reg        <= thr_next;
      hs_reg         <= hs_next;
      run_reg        <= run_next;
      clear_reg      <= clear_next;
      over_first_reg <= over_first_next;
      start_q        <= start;
      pause_q        <= pause;
    end
  end

  always_comb begin
    state_next      = state_reg;
    presc_next      = presc_reg;
    cnt_next        = cnt_reg;
    level_next      = level_reg;
    thr_next        = thr_reg;
    hs_next         = hs_reg;
    run_next        = run_reg;
    clear_next      = 1'b0;
    over_first_next = 1'b0;
    case (state_reg)
      ST_IDLE: ;
      ST_COUNTDOWN: begin
        if (presc_reg == PRESC_LAST) begin
          presc_next = '0;
          if (cnt_reg == 2'd1) begin
            state_next = ST_PLAY;
            cnt_next   = '0;
            run_next   = 1'b1;
          end else begin
            cnt_next = cnt_reg - 2'd1;
          end
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      ST_PLAY: begin
        if (step) begin
          level_next = level_reg + 3'd1;
          thr_next   = thr_reg + 8'(LEVEL_STEP);
        end
        if (end_game) begin
          state_next      = ST_OVER;
          run_next        = 1'b0;
          over_first_next = 1'b1;
        end else if (p_rise) begin
          state_next = ST_PAUSED;
          run_next   = 1'b0;
        end
      end
      ST_PAUSED: begin
        if (end_game) begin
          state_next      = ST_OVER;
          over_first_next = 1'b1;
        end else if (p_rise) begin
          state_next = ST_PLAY;
          run_next   = 1'b1;
        end
      end
      ST_OVER: begin
        // Final score is captured only on the entry cycle, even if a restart arrives then.
        if (over_first_reg && (score > hs_reg))
          hs_next = score;
      end
      default: begin
        state_next = ST_IDLE;
        presc_next = '0;
        cnt_next   = '0;
        level_next = '0;
        thr_next   = 8'(LEVEL_STEP);
        run_next   = 1'b0;
      end
    endcase
    if (s_rise && legal) begin
      state_next      = ST_COUNTDOWN;
      clear_next      = 1'b1;
      cnt_next        = 2'(COUNTDOWN_SEC);
      presc_next      = '0;
      level_next      = '0;
      thr_next        = 8'(LEVEL_STEP);
      run_next        = 1'b0;
      over_first_next = 1'b0;
    end
  end

  assign state      = state_reg;
  assign run        = run_reg;
  assign clear      = clear_reg;
  assign countdown  = cnt_reg;
  assign level      = level_reg;
  assign high_score = hs_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random stimulus, all outputs checked every
// cycle against an elapsed-time behavioural model of the game flow.
module tb_game_ctrl;
  localparam int HZ = 10;
  localparam int CD = 3;
  localparam int LS = 10;
  localparam int ML = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, end_game = 1'b0;
  logic [6:0] score = '0;
  logic       run, clear;
  logic [2:0] state, level;
  logic [1:0] countdown;
  logic [6:0] high_score;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  game_ctrl #(.CLK_HZ(HZ), .COUNTDOWN_SEC(CD), .LEVEL_STEP(LS), .MAX_LEVEL(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .end_game(end_game),
    .score(score), .run(run), .clear(clear), .state(state), .countdown(countdown),
    .level(level), .high_score(high_score)
  );

  always #5 clk = ~clk;

  // Model: state number, cycles elapsed since the countdown began, level, best score.
  int m_state = 0, m_el = 0, m_level = 0, m_hs = 0;
  bit m_clear = 0, m_first = 0, m_sq = 0, m_pq = 0;

  always @(posedge clk) begin
    bit sr, pr, nfirst;
    if (rst) begin
      m_state = 0; m_el = 0; m_level = 0; m_hs = 0;
      m_clear = 0; m_first = 0; m_sq = 0; m_pq = 0;
    end else begin
      sr = start && !m_sq;
      pr = pause && !m_pq;
      m_sq = start;
      m_pq = pause;
      nfirst = 0;
      m_clear = 0;
      if (m_state == 4 && m_first && int'(score) > m_hs) m_hs = int'(score);
      if (sr) begin
        m_state = 1; m_clear = 1; m_el = 0; m_level = 0;
      end else begin
        case (m_state)
          1: begin
            m_el++;
            if (m_el == CD * HZ) m_state = 2;
          end
          2: begin
            if (int'(score) >= LS * (m_level + 1) && m_level < ML) m_level++;
            if (end_game) begin m_state = 4; nfirst = 1; end
            else if (pr) m_state = 3;
          end
          3: begin
            if (end_game) begin m_state = 4; nfirst = 1; end
            else if (pr) m_state = 2;
          end
          default: ;
        endcase
      end
      m_first = nfirst;
    end
  end

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_state", int'(state), m_state);
      cmp("m_run", int'(run), (m_state == 2) ? 1 : 0);
      cmp("m_clear", int'(clear), int'(m_clear));
      cmp("m_countdown", int'(countdown), (m_state == 1) ? (CD - m_el / HZ) : 0);
      cmp("m_level", int'(level), m_level);
      cmp("m_high_score", int'(high_score), m_hs);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic to_play();
    press_start();
    tick(CD * HZ);
  endtask

  initial begin
    tick(2);
    chk_en = 1'b1;
    cmp("reset_state", int'(state), 0);
    cmp("reset_hs", int'(high_score), 0);
    rst = 1'b0;
    tick(3);

    // T1: countdown timing
    press_start();
    cmp("t1_state", int'(state), 1);
    cmp("t1_clear", int'(clear), 1);
    cmp("t1_cd3", int'(countdown), 3);
    tick();
    cmp("t1_clear_off", int'(clear), 0);
    tick(9);
    cmp("t1_cd2", int'(countdown), 2);
    tick(10);
    cmp("t1_cd1", int'(countdown), 1);
    tick(9);
    cmp("t1_not_yet", int'(state), 1);
    tick();
    cmp("t1_play", int'(state), 2);
    cmp("t1_run", int'(run), 1);
    $display("T1 countdown done state=%0d run=%0d", state, run);

    // T2: held pause toggles once
    pause = 1'b1; tick();
    cmp("t2_paused", int'(state), 3);
    cmp("t2_run0", int'(run), 0);
    tick(19);
    cmp("t2_held", int'(state), 3);
    pause = 1'b0; tick();
    pause = 1'b1; tick();
    cmp("t2_resume", int'(state), 2);
    pause = 1'b0;
    $display("T2 pause/resume done state=%0d", state);

    // T3: level steps and saturation
    score = 7'd25; tick();
    cmp("t3_lvl1", int'(level), 1);
    tick();
    cmp("t3_lvl2", int'(level), 2);
    score = 7'd99; tick(8);
    cmp("t3_sat", int'(level), 7);
    score = 7'd5; tick(3);
    cmp("t3_hold", int'(level), 7);
    $display("T3 level done level=%0d", level);

    // T4: end_game beats pause; high score latch
    score = 7'd42; end_game = 1'b1; pause = 1'b1; tick();
    cmp("t4_over", int'(state), 4);
    end_game = 1'b0; pause = 1'b0; tick();
    cmp("t4_hs42", int'(high_score), 42);
    to_play();
    score = 7'd30; end_game = 1'b1; tick();
    end_game = 1'b0; tick();
    cmp("t4_hs_keep", int'(high_score), 42);
    $display("T4 game over done high_score=%0d", high_score);

    // T5: reset mid-countdown and mid-pause, start held through reset
    press_start(); tick(10);
    cmp("t5_cd2", int'(countdown), 2);
    rst = 1'b1; tick(); rst = 1'b0;
    cmp("t5a_state", int'(state), 0);
    cmp("t5a_cd", int'(countdown), 0);
    cmp("t5a_hs", int'(high_score), 0);
    to_play();
    pause = 1'b1; tick(); pause = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    cmp("t5b_state", int'(state), 0);
    cmp("t5b_run", int'(run), 0);
    start = 1'b1; rst = 1'b1; tick(); rst = 1'b0; tick();
    cmp("t5c_held_start", int'(state), 1);
    start = 1'b0;
    $display("T5 reset done state=%0d", state);

    // T6: restart from PLAY at level 3
    tick(CD * HZ);
    score = 7'd35; tick(4);
    cmp("t6_lvl3", int'(level), 3);
    press_start();
    cmp("t6_state", int'(state), 1);
    cmp("t6_clear", int'(clear), 1);
    cmp("t6_lvl0", int'(level), 0);
    cmp("t6_cd3", int'(countdown), 3);
    tick(CD * HZ - 1);
    cmp("t6_not_yet", int'(state), 1);
    tick();
    cmp("t6_play", int'(state), 2);
    $display("T6 restart done state=%0d", state);

    // Random traffic against the model
    for (int i = 0; i < 5000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      start    = ($urandom_range(0, 119) == 0);
      pause    = ($urandom_range(0, 9) == 0) ? ~pause : pause;
      end_game = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) score = 7'($urandom_range(0, 127));
      tick();
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0; end_game = 1'b0;
    tick(2);
    $display("RANDOM phase done high_score=%0d", high_score);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
